sdpram_rd_streamer: RTL

Read-side sequencer sitting directly in front of the 512x8 simple dual-port RAM core, which has a registered output and `rd_oce`. On a start command it streams a block of `length` bytes, beginning at `base_addr`, from the RAM read port onto a valid/ready byte stream. It hides the RAM's fixed 2-cycle read latency behind a small credit-controlled FIFO, so downstream backpressure never loses data and never stalls the RAM pipeline. The RAM write side is owned by other logic; both sides run on `clk` in this configuration.

---
 rtl/sdpram_rd_streamer_pkg.sv | 26 ++
 rtl/sdpram_rd_streamer_if.sv | 25 ++
 rtl/sdpram_rd_streamer_stream_sync_fifo.sv | 63 ++++++
 rtl/sdpram_rd_streamer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sdpram_rd_streamer_pkg.sv
// Shared types and defaults for the SDP RAM read streamer.
package sdpram_rd_pkg;

    localparam int unsigned ADDR_W_DEF     = 9;
    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned LEN_W_DEF      = 10;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned RD_LATENCY     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    // Number of reads currently travelling through the RAM pipeline.
    function automatic int unsigned count_ones(input logic [RD_LATENCY-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sdpram_rd_streamer_if.sv
// Valid/ready byte stream with end-of-block marker.
interface sdpram_rd_streamer_if
    import sdpram_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/sdpram_rd_streamer_stream_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
module stream_sync_fifo
    import sdpram_rd_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W_DEF + 1,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    // Output forced to zero when empty so the stream reads as reset-clean.
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sdpram_rd_streamer.sv
// Streams a block of bytes out of the SDP RAM read port, hiding the RAM's
// fixed read latency behind a credit-controlled output FIFO.
module sdpram_rd_streamer
    import sdpram_rd_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned LEN_W      = LEN_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic              ram_rd_clk_en,
    output logic              ram_rd_oce,
    input  logic [DATA_W-1:0] ram_rd_data,
    sdpram_rd_streamer_if.master m_stream
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_t             state;
    logic [LEN_W-1:0]      remaining;
    logic                  zero_len;
    logic [RD_LATENCY-1:0] sr_valid;
    logic [RD_LATENCY-1:0] sr_last;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         inflight;
    logic [CW:0]           occupancy;
    logic                  issue;
    logic                  issue_last;
    logic                  pop;
    logic                  finish;
    logic                  fifo_flush;
    logic                  fifo_empty;
    logic                  fifo_last;
    logic [DATA_W-1:0]     fifo_data;

    // A read is only issued if a FIFO slot is already reserved for its data.
    assign inflight   = CW'(count_ones(sr_valid));
    assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue      = (state == ST_RUN) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign issue_last = issue && (remaining == LEN_W'(1));

    assign pop        = m_stream.m_valid && m_stream.m_ready;
    assign finish     = (state == ST_DRAIN) && (zero_len || (pop && m_stream.m_last));
    assign fifo_flush = abort && (state != ST_IDLE);

    assign busy          = (state != ST_IDLE);
    assign ram_rd_clk_en = busy || (sr_valid != '0);
    assign ram_rd_oce    = ram_rd_clk_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ram_rd_addr <= '0;
            remaining   <= '0;
            zero_len    <= 1'b0;
            done        <= 1'b0;
            sr_valid    <= '0;
            sr_last     <= '0;
        end else begin
            done     <= 1'b0;
            sr_valid <= {sr_valid[RD_LATENCY-2:0], issue};
            sr_last  <= {sr_last[RD_LATENCY-2:0], issue_last};
            if (fifo_flush) begin
                // Clearing the valids discards any RAM data still in flight.
                state    <= ST_IDLE;
                sr_valid <= '0;
                sr_last  <= '0;
                zero_len <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            ram_rd_addr <= base_addr;
                            remaining   <= length;
                            zero_len    <= (length == '0);
                            state       <= (length == '0) ? ST_DRAIN : ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (issue) begin
                            ram_rd_addr <= ram_rd_addr + 1'b1;
                            remaining   <= remaining - 1'b1;
                            if (issue_last) state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (finish) begin
                            state    <= ST_IDLE;
                            done     <= 1'b1;
                            zero_len <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    stream_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (sr_valid[RD_LATENCY-1]),
        .push_data ({sr_last[RD_LATENCY-1], ram_rd_data}),
        .pop       (pop),
        .pop_data  ({fifo_last, fifo_data}),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign m_stream.m_data  = fifo_data;
    assign m_stream.m_valid = !fifo_empty;
    assign m_stream.m_last  = fifo_last;

endmodule
